axi_read_responder: RTL and testbench
=====================================

# axi_read_responder

Subordinate-side AXI read responder at the far end of the address mapper's AR path. It accepts AR requests (already tagged with a master ID), walks each burst beat by beat against a single-port backing memory, and returns R beats carrying that ID back toward the read response router. It is the responder counterpart to the master-side AR queue and arbiter.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (bytes per beat = DATA_W/8; power of two, 8–128)
- MID_W, 4, mapped master-ID width
- AR_DEPTH, 2, AR buffer entries (power of two, ≥2)
- MEM_BASE, 32'h0, first valid byte address
- MEM_BYTES, 32'h10000, decoded region size in bytes

Ports:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- ar_valid  in  1  AR request valid
- ar_ready  out  1  AR buffer has space
- ar_addr  in  ADDR_W  start byte address
- ar_mid_id  in  MID_W  mapped master ID
- ar_size  in  3  log2 bytes per beat
- ar_len  in  8  beats minus one
- ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- r_valid  out  1  R beat valid
- r_ready  in  1  router accepts beat
- r_data  out  DATA_W  beat data
- r_mid_id  out  MID_W  echoed ar_mid_id
- r_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- r_last  out  1  final beat of burst
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  beat address, aligned down to DATA_W/8
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid, ≥1 cycle after acceptance
- mem_rdata  in  DATA_W  read data

## Operation
- AR buffer: FIFO of AR_DEPTH entries; push on ar_valid&&ar_ready; ar_ready = !full. Push while full cannot occur. A pop and push in the same cycle both take effect; count unchanged.
- FSM states: IDLE, REQ, WAIT, SEND.
  - IDLE: if buffer non-empty, pop head into burst registers (addr, mid, size, len, burst, beat counter = 0, err) -> REQ.
  - REQ: if err != OKAY, load r_data = 0 -> SEND without a memory access. Otherwise hold mem_req=1, mem_addr=current beat address; on mem_ready -> WAIT.
  - WAIT: on mem_rvalid, capture mem_rdata into r_data -> SEND.
  - SEND: r_valid=1; on r_ready: if beat counter == len -> IDLE, else increment counter, advance address -> REQ.
- Exactly one memory request outstanding. mem_rvalid outside WAIT is ignored.
- Error classification, fixed at pop and applied to every beat of the burst:
  - DECERR: start address outside [MEM_BASE, MEM_BASE+MEM_BYTES).
  - SLVERR: 1<<ar_size > DATA_W/8; burst 11; or WRAP with len not in {1,3,7,15}. DECERR takes priority.
- Address advance, with step = 1<<size:
  - FIXED: unchanged.
  - INCR: addr+step, ADDR_W modulo arithmetic. The first increment aligns the address down to step.
  - WRAP: with span = (len+1)*step and base = addr aligned down to span, next = base + ((addr+step-base) mod span).
  - INCR that crosses the region end mid-burst: remaining beats get DECERR with data 0 and no memory access. Checked per beat.
- r_last = (beat counter == len) while in SEND.

## Timing
- Reset values: ar_ready=1 (buffer empty), r_valid=0, r_last=0, r_resp=00, r_data=0, r_mid_id=0, mem_req=0, mem_addr=0. FSM returns to IDLE and the buffer empties.
- Reset mid-burst discards all buffered and in-flight bursts; no partial beats after release.
- Latency: for an AR handshake at edge E into an idle, empty block:
  - IDLE pops at E+1.
  - mem_req is high in the cycle after E+1.
  - r_valid rises the cycle after mem_rvalid.
  - For error bursts, r_valid rises the cycle after the REQ cycle.
- R stability: while r_valid && !r_ready, r_data, r_resp, r_mid_id and r_last hold.
- mem_req and mem_addr hold until mem_ready.
- Throughput: at most one beat per 3 cycles with zero-wait memory. Bursts complete in order; no interleaving.

## Test plan
- INCR, addr 0x100, size 2, len 3, mem returns addr-as-data, r_ready=1 -> beats 0x100/0x104/0x108/0x10C, resp 00, r_last only on the 4th, r_mid_id echoed.
- WRAP, addr 0x38, size 2, len 3 -> mem_addr sequence 0x38, 0x3C, 0x30, 0x34.
- Address 0x20000 with default params, len 1 -> two beats, DECERR, data 0, mem_req never asserted. Burst 11 -> SLVERR.
- Three back-to-back ARs with r_ready low -> ar_ready drops after two buffered beyond the active burst. With r_ready toggled randomly, R payload is stable under stall and bursts return in order.
- INCR from MEM_BASE+MEM_BYTES-8, size 2, len 3 -> beats OKAY, OKAY, DECERR, DECERR; mem_req is issued for the first two beats only.
- Assert nRST while in WAIT -> all outputs take reset values immediately. A late mem_rvalid is ignored, and the next AR completes normally.

Source files
------------

// File: rtl/axi_read_responder.sv
// AXI read responder: buffers AR requests, walks each burst beat by beat against a
// single-port memory and returns tagged R beats in order, with per-burst error classification.
module axi_read_responder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       MID_W     = 4,
    parameter int unsigned       AR_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] MEM_BASE  = '0,
    parameter logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(32'h10000)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [MID_W-1:0]  ar_mid_id,
    input  logic [2:0]        ar_size,
    input  logic [7:0]        ar_len,
    input  logic [1:0]        ar_burst,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic [MID_W-1:0]  r_mid_id,
    output logic [1:0]        r_resp,
    output logic              r_last,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned PTR_W     = $clog2(AR_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned LOG_BYTES = $clog2(DATA_W / 8);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SEND} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MID_W-1:0]  mid;
        logic [2:0]        size;
        logic [7:0]        len;
        logic [1:0]        burst;
    } ar_t;

    state_t            state, state_nx;
    ar_t               fifo_mem [AR_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, empty;
    ar_t               head, cur;
    logic [1:0]        head_err, cur_err;
    logic [7:0]        beat_cnt;
    logic              last_beat;
    logic [ADDR_W-1:0] step, span, incr_next, wrap_base, wrap_next, next_addr;
    logic [2:0]        wrap_log;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= MEM_BASE) && ((a - MEM_BASE) < MEM_BYTES);
    endfunction

    // AR buffer
    assign empty    = (count == '0);
    assign ar_ready = (count != CNT_W'(AR_DEPTH));
    assign push     = ar_valid && ar_ready;
    assign pop      = (state == S_IDLE) && !empty;
    assign head     = fifo_mem[rd_ptr];

    // NOTE: request storage is pure data qualified by count, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= '{ar_addr, ar_mid_id, ar_size, ar_len, ar_burst};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head_err = RESP_OKAY;
        if (!in_range(head.addr))
            head_err = RESP_DECERR;
        else if ((head.size > 3'(LOG_BYTES)) || (head.burst == 2'b11) ||
                 ((head.burst == BURST_WRAP) && !(head.len inside {8'd1, 8'd3, 8'd7, 8'd15})))
            head_err = RESP_SLVERR;
    end

    // Beat address advance; WRAP span is a power of two because illegal lengths are SLVERR.
    always_comb begin
        step      = ADDR_W'(1) << cur.size;
        incr_next = (cur.addr & ~(step - ADDR_W'(1))) + step;
        case (cur.len)
            8'd1:    wrap_log = 3'd1;
            8'd3:    wrap_log = 3'd2;
            8'd7:    wrap_log = 3'd3;
            default: wrap_log = 3'd4;
        endcase
        span      = step << wrap_log;
        wrap_base = cur.addr & ~(span - ADDR_W'(1));
        wrap_next = wrap_base + ((cur.addr + step - wrap_base) & (span - ADDR_W'(1)));
        case (cur.burst)
            BURST_INCR: next_addr = incr_next;
            BURST_WRAP: next_addr = wrap_next;
            default:    next_addr = cur.addr;
        endcase
    end

    assign last_beat = (beat_cnt == cur.len);

    // NOTE: sequential state is always updated with non-blocking assignments.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (!empty) state_nx = S_REQ;
            S_REQ: begin
                if (cur_err != RESP_OKAY) state_nx = S_SEND;
                else if (mem_ready)       state_nx = S_WAIT;
            end
            S_WAIT: if (mem_rvalid) state_nx = S_SEND;
            S_SEND: if (r_ready)    state_nx = last_beat ? S_IDLE : S_REQ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == S_REQ) && (cur_err == RESP_OKAY);
        r_valid = (state == S_SEND);
        r_last  = r_valid && last_beat;
        r_resp  = r_valid ? cur_err : RESP_OKAY;
    end

    assign mem_addr = cur.addr & ~ADDR_W'(DATA_W / 8 - 1);
    assign r_mid_id = cur.mid;

    // Burst registers; an INCR that leaves the region turns the rest of the burst into DECERR.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur      <= '0;
            cur_err  <= RESP_OKAY;
            beat_cnt <= '0;
            r_data   <= '0;
        end else begin
            if (pop) begin
                cur      <= head;
                cur_err  <= head_err;
                beat_cnt <= '0;
            end
            if ((state == S_REQ) && (cur_err != RESP_OKAY)) r_data <= '0;
            if ((state == S_WAIT) && mem_rvalid)           r_data <= mem_rdata;
            if ((state == S_SEND) && r_ready && !last_beat) begin
                cur.addr <= next_addr;
                beat_cnt <= beat_cnt + 8'd1;
                if ((cur.burst == BURST_INCR) && (cur_err == RESP_OKAY) && !in_range(incr_next))
                    cur_err <= RESP_DECERR;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed cases plus randomized bursts,
// scored against a per-beat closed-form model of the burst address and error rules.
module tb_axi_read_responder;

    localparam int unsigned     ADDR_W = 32;
    localparam int unsigned     DATA_W = 32;
    localparam int unsigned     MID_W  = 4;
    localparam longint unsigned BASE   = 64'h0;
    localparam longint unsigned BYTES  = 64'h10000;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              ar_valid = 1'b0;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr = '0;
    logic [MID_W-1:0]  ar_mid_id = '0;
    logic [2:0]        ar_size = '0;
    logic [7:0]        ar_len = '0;
    logic [1:0]        ar_burst = '0;
    logic              r_valid;
    logic              r_ready = 1'b0;
    logic [DATA_W-1:0] r_data;
    logic [MID_W-1:0]  r_mid_id;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 CLK = ~CLK;

    axi_read_responder dut (
        .CLK(CLK), .nRST(nRST),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_mid_id(ar_mid_id),
        .ar_size(ar_size), .ar_len(ar_len), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_mid_id(r_mid_id),
        .r_resp(r_resp), .r_last(r_last),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  mid;
        logic        last;
    } beat_t;

    beat_t       exp_r[$];
    logic [31:0] exp_mem[$];
    int n_cmp = 0, n_bad = 0;
    int rr_mode = 1;            // 0: r_ready low, 1: high, 2: random
    int lat_min = 0, lat_max = 2;
    int n_mem_acc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected beats computed directly from the burst rules, one closed-form address per beat.
    function automatic void model_push(input logic [31:0] a, input logic [3:0] mid,
                                       input logic [2:0] sz, input logic [7:0] len,
                                       input logic [1:0] bt);
        longint unsigned step, span, wbase;
        logic [1:0]  berr, resp;
        logic [31:0] ai;
        bit          gone_out;
        beat_t       b;
        step  = 64'd1 << sz;
        span  = (longint'(len) + 1) * step;
        wbase = a - (a % span);
        if (a < BASE || a >= BASE + BYTES)                           berr = DECERR;
        else if (step > DATA_W / 8 || bt == RSVD ||
                 (bt == WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))) berr = SLVERR;
        else                                                          berr = OKAY;
        gone_out = 0;
        for (int i = 0; i <= int'(len); i++) begin
            case (bt)
                INCR:    ai = (i == 0) ? a : 32'((a & ~32'(step - 1)) + longint'(i) * step);
                WRAP:    ai = 32'(wbase + ((a - wbase) + longint'(i) * step) % span);
                default: ai = a;
            endcase
            resp = berr;
            if (berr == OKAY && bt == INCR && (ai < BASE || ai >= BASE + BYTES)) gone_out = 1;
            if (gone_out) resp = DECERR;
            b.data = (resp == OKAY) ? {ai[31:2], 2'b00} : 32'h0;
            b.resp = resp;
            b.mid  = mid;
            b.last = (i == int'(len));
            if (resp == OKAY) exp_mem.push_back(b.data);
            exp_r.push_back(b);
        end
    endfunction

    // Environment: monitors on the falling edge, memory and r_ready driven after the rising edge.
    initial begin
        bit          r_hold = 0, m_hold = 0, pend = 0;
        logic [39:0] r_held;
        logic [32:0] m_held;
        int          pend_cnt = 0;
        logic [31:0] pend_addr = '0;
        beat_t       b;
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                exp_r.delete();
                exp_mem.delete();
                r_hold = 0;
                m_hold = 0;
            end else begin
                if (r_hold) check("r_stable", {r_valid, r_data, r_resp, r_mid_id, r_last}, r_held);
                if (m_hold) check("mem_hold", {mem_req, mem_addr}, m_held);
                r_hold = r_valid && !r_ready;
                r_held = {r_valid, r_data, r_resp, r_mid_id, r_last};
                m_hold = mem_req && !mem_ready;
                m_held = {mem_req, mem_addr};
                if (r_valid && exp_r.size() == 0) check("r_unexpected", r_valid, 0);
                else if (r_valid && r_ready) begin
                    b = exp_r.pop_front();
                    check("r_data", r_data, b.data);
                    check("r_resp", r_resp, b.resp);
                    check("r_mid_id", r_mid_id, b.mid);
                    check("r_last", r_last, b.last);
                end
                if (mem_req && exp_mem.size() == 0) check("mem_unexpected", mem_req, 0);
                else if (mem_req && mem_ready) begin
                    check("mem_addr", mem_addr, exp_mem.pop_front());
                    pend      = 1;
                    pend_cnt  = $urandom_range(lat_max, lat_min);
                    pend_addr = mem_addr;
                    n_mem_acc++;
                end
                if (ar_valid && ar_ready) model_push(ar_addr, ar_mid_id, ar_size, ar_len, ar_burst);
            end
            @(posedge CLK);
            #1;
            mem_ready  = ($urandom_range(3, 0) != 0);
            mem_rvalid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_addr;
                    pend       = 0;
                end else pend_cnt--;
            end else if ($urandom_range(7, 0) == 0) begin
                mem_rvalid = 1'b1;   // stray read data, must be ignored
                mem_rdata  = $urandom;
            end
            r_ready = (rr_mode == 0) ? 1'b0 : (rr_mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
        end
    end

    task automatic check_reset_outputs();
        check("rst_ar_ready", ar_ready, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_last", r_last, 0);
        check("rst_r_resp", r_resp, 0);
        check("rst_r_data", r_data, 0);
        check("rst_r_mid_id", r_mid_id, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
    endtask

    // lat_chk: 0 none, 1 memory-path latency, 2 error-path latency (both require an idle block).
    task automatic send_ar(input logic [31:0] a, input logic [3:0] mid, input logic [2:0] sz,
                           input logic [7:0] len, input logic [1:0] bt, input int lat_chk);
        bit got = 0;
        ar_valid  = 1'b1;
        ar_addr   = a;
        ar_mid_id = mid;
        ar_size   = sz;
        ar_len    = len;
        ar_burst  = bt;
        for (int t = 0; t < 400; t++) begin
            @(negedge CLK);
            if (ar_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("ar_accept_timeout", ar_ready, 1);
        @(posedge CLK);
        #1;
        ar_valid = 1'b0;
        if (lat_chk == 1) begin
            @(negedge CLK);
            check("lat_pop_no_req", mem_req, 0);
            @(negedge CLK);
            check("lat_req", mem_req, 1);
        end else if (lat_chk == 2) begin
            @(negedge CLK);
            @(negedge CLK);
            check("err_lat_req", r_valid, 0);
            check("err_no_mem", mem_req, 0);
            @(negedge CLK);
            check("err_lat_send", r_valid, 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_r.size() != 0 || r_valid) && t < 4000) begin
            @(posedge CLK);
            t++;
        end
        #1;
        check("drain_left", exp_r.size(), 0);
        check("drain_mem_left", exp_mem.size(), 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        int acc0, gap, sel, len;
        logic [31:0] a;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs();
        nRST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // INCR burst with memory returning its address as data
        rr_mode = 1;
        send_ar(32'h100, 4'h5, 3'd2, 8'd3, INCR, 1);
        drain();

        // WRAP burst: addresses 0x38, 0x3C, 0x30, 0x34
        send_ar(32'h38, 4'h9, 3'd2, 8'd3, WRAP, 1);
        drain();

        // Error bursts: out of region, reserved burst, oversize beat, illegal wrap length
        send_ar(32'h20000, 4'h3, 3'd2, 8'd1, INCR, 2);
        drain();
        send_ar(32'h40, 4'h7, 3'd2, 8'd0, RSVD, 2);
        drain();
        send_ar(32'h80, 4'h1, 3'd3, 8'd1, INCR, 0);
        send_ar(32'h80, 4'h2, 3'd2, 8'd2, WRAP, 0);
        send_ar(32'h44, 4'hC, 3'd1, 8'd2, FIXED, 0);
        drain();

        // INCR that runs off the end of the region after two beats
        send_ar(32'hFFF8, 4'hA, 3'd2, 8'd3, INCR, 0);
        drain();

        // Buffer fills with r_ready low: one burst active, two buffered
        rr_mode = 0;
        send_ar(32'h200, 4'h1, 3'd2, 8'd1, INCR, 0);
        send_ar(32'h300, 4'h2, 3'd2, 8'd1, INCR, 0);
        send_ar(32'h400, 4'h3, 3'd2, 8'd1, INCR, 0);
        @(negedge CLK);
        check("ar_ready_full", ar_ready, 0);
        rr_mode = 2;
        drain();

        // Randomized bursts under random r_ready and memory latency
        lat_min = 0;
        lat_max = 3;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(9, 0);
            if (sel < 6)       a = $urandom_range(32'h3FF, 0);
            else if (sel < 8)  a = 32'h10000 - $urandom_range(64, 1);
            else if (sel == 8) a = 32'h10000 + $urandom_range(255, 0);
            else               a = $urandom;
            len = ($urandom_range(7, 0) == 0) ? 15 : $urandom_range(7, 0);
            gap = $urandom_range(3, 0);
            repeat (gap) begin
                @(posedge CLK);
                #1;
            end
            send_ar(a, 4'($urandom), 3'($urandom_range(3, 0)), 8'(len),
                    ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : INCR, 0);
        end
        drain();

        // Reset while a memory read is outstanding, then a normal burst
        rr_mode = 1;
        lat_min = 6;
        lat_max = 6;
        acc0 = n_mem_acc;
        send_ar(32'h500, 4'h6, 3'd2, 8'd2, INCR, 0);
        for (int t = 0; t < 100; t++) begin
            @(posedge CLK);
            #2;
            if (n_mem_acc != acc0) break;
        end
        check("mem_accept_before_reset", n_mem_acc - acc0, 1);
        nRST = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        repeat (12) @(posedge CLK);
        #1;
        check("post_reset_idle", r_valid, 0);
        lat_min = 0;
        lat_max = 2;
        send_ar(32'h600, 4'hB, 3'd2, 8'd1, INCR, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
